// File: rtl/booth_mac_ctrl.sv
// booth_mac_ctrl: feeds a burst of signed operand pairs to a fixed-latency multiplier and accumulates the products
module booth_mac_ctrl #(
  parameter int LAT = 6,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [3:0]       len,
  input  logic             in_valid,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             in_ready,
  output logic             mul_start,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] rem, cnt;
  logic [ACC_W-1:0] p_ext;
  assign p_ext = ACC_W'($signed(mul_p));
  assign in_ready = state == FETCH;
  assign mul_start = state == START;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = go ? (len == 4'd0 ? DONE : FETCH) : IDLE;
      FETCH: state_nx = in_valid ? START : FETCH;
      START: state_nx = WAIT;
      WAIT:  state_nx = cnt != 4'd0 ? WAIT : (rem == 4'd1 ? DONE : FETCH);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
      acc <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (go) begin
          rem <= len;
          acc <= '0;
        end
        FETCH: if (in_valid) begin
          mul_a <= in_a;
          mul_b <= in_b;
        end
        START: cnt <= 4'(LAT - 1);
        // cnt==0 marks the cycle in which the multiplier's product is valid
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          acc <= acc + p_ext;
          rem <= rem - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mac_ctrl.sv
// tb_booth_mac_ctrl: random and directed bursts scored against a dot-product model at two accumulator widths
module tb_booth_mac_ctrl;
  localparam int LAT = 6;
  logic clk = 0, rst_n = 0, go = 0, in_valid = 0;
  logic [3:0] len = 0, in_a = 0, in_b = 0;
  logic [7:0] mul_p = 0;
  logic in_ready, mul_start, busy, done;
  logic [3:0] mul_a, mul_b;
  logic [11:0] acc;
  logic in_ready8, mul_start8, busy8, done8;
  logic [3:0] mul_a8, mul_b8;
  logic [7:0] acc8;

  booth_mac_ctrl #(.LAT(LAT), .ACC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .len(len), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .acc(acc), .busy(busy), .done(done));
  booth_mac_ctrl #(.LAT(LAT), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .go(go), .len(len), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready8), .mul_start(mul_start8), .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p),
    .acc(acc8), .busy(busy8), .done(done8));

  always #5 clk = ~clk;

  typedef struct {int a; int b;} pair_t;
  pair_t pq[$];
  pair_t p;
  int e12q[$], e8q[$];
  int checks = 0, errors = 0;
  int ta[16], tb_[16], gap[16];
  int nstart = 0, ndone = 0, since = 0;
  bit tight = 0, first = 1, chk_idle = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // multiplier model: product presented exactly in cycle T+LAT, junk otherwise
  int mcnt = -1, mprod = 0;
  always @(negedge clk) begin
    if (mul_start) begin
      mprod = $signed(mul_a) * $signed(mul_b);
      mcnt = LAT;
    end else if (mcnt >= 0) mcnt--;
    mul_p = (mcnt == 0) ? 8'(mprod) : 8'($urandom);
  end

  always @(negedge clk) begin
    if (chk_idle) begin
      chk("busy_after_done", int'(busy), 0);
      chk_idle = 0;
    end
    if (rst_n) begin
      if (mul_start) begin
        nstart++;
        if (pq.size() == 0) chk("spurious_mul_start", 1, 0);
        else begin
          p = pq.pop_front();
          chk("mul_a", int'(mul_a), p.a & 15);
          chk("mul_b", int'(mul_b), p.b & 15);
        end
        if (tight && !first) chk("start_spacing", since, LAT + 2);
        first = 0;
        since = 0;
      end
      since++;
      if (done) begin
        if (e12q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          chk("acc12", int'(acc), e12q.pop_front());
          chk("acc8", int'(acc8), e8q.pop_front());
        end
        chk("done8", int'(done8), 1);
        ndone++;
        first = 1;
        chk_idle = 1;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic run(input int n, input bit midgo);
    int s, d0, st0;
    bit ok;
    s = 0;
    for (int i = 0; i < n; i++) s += ta[i] * tb_[i];
    e12q.push_back(s & 'hFFF);
    e8q.push_back(s & 'hFF);
    d0 = ndone;
    st0 = nstart;
    @(posedge clk); #1;
    go = 1;
    len = 4'(n);
    @(posedge clk); #1;
    go = 0;
    len = 4'($urandom);
    if (n == 0) begin
      chk("empty_done_next_cycle", int'(done), 1);
      chk("empty_in_ready", int'(in_ready), 0);
    end
    for (int i = 0; i < n; i++) begin
      wait_ready(ok);
      if (!ok) break;
      for (int g = 0; g < gap[i]; g++) begin
        chk("ready_in_gap", int'(in_ready), 1);
        @(negedge clk);
      end
      in_valid = 1;
      in_a = 4'(ta[i]);
      in_b = 4'(tb_[i]);
      pq.push_back('{ta[i], tb_[i]});
      @(posedge clk); #1;
      in_valid = 0;
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      if (midgo && i == 0) begin
        go = 1;
        len = 4'd9;
        @(posedge clk); #1;
        go = 0;
      end
    end
    for (int k = 0; k < 40 && ndone == d0; k++) @(posedge clk);
    chk("done_seen", int'(ndone > d0), 1);
    chk("start_count", nstart - st0, n);
    @(posedge clk);
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) gap[i] = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_acc"}, int'(acc), 0);
    chk({tag, "_mul_a"}, int'(mul_a), 0);
    chk({tag, "_mul_b"}, int'(mul_b), 0);
    chk({tag, "_mul_start"}, int'(mul_start), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    bit ok;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear_gaps();
    tight = 1;
    ta[0] = 3; tb_[0] = -2;
    run(1, 0);
    ta[0:3] = '{7, -8, -8, 1};
    tb_[0:3] = '{7, -8, 7, -1};
    run(4, 0);
    run(0, 0);
    tight = 0;
    ta[0:1] = '{2, -4};
    tb_[0:1] = '{3, 5};
    gap[1] = 3;
    run(2, 1);
    clear_gaps();
    tight = 1;
    for (int i = 0; i < 15; i++) begin
      ta[i] = -8;
      tb_[i] = -8;
    end
    run(15, 0);
    tight = 0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        ta[i] = int'($urandom_range(15)) - 8;
        tb_[i] = int'($urandom_range(15)) - 8;
        gap[i] = int'($urandom_range(3));
      end
      run(int'($urandom_range(15)), r[0]);
    end
    clear_gaps();
    @(posedge clk); #1;
    go = 1;
    len = 4'd2;
    @(posedge clk); #1;
    go = 0;
    wait_ready(ok);
    in_valid = 1;
    in_a = 4'd3;
    in_b = 4'd4;
    pq.push_back('{3, 4});
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 check_zero("async_reset");
    pq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    ta[0] = 5; tb_[0] = 5;
    run(1, 0);
    chk("pair_queue_empty", pq.size(), 0);
    chk("exp_queue_empty", e12q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
